// File: rtl/mips_debug_sequencer_pkg.sv
// Shared opcodes, FSM encoding and sizes for the MIPS debug sequencer.
package mips_dbg_pkg;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_RST  = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = $clog2(RF_DEPTH);
  localparam int PMEM_AW  = 6;

  typedef enum logic [2:0] {
    IDLE,
    LD_WR,
    RD_WAIT,
    CLK_HI,
    CLK_LO,
    RST_HOLD,
    DMP_SET,
    RSP
  } dbg_state_e;

endpackage

// File: rtl/mips_debug_sequencer_if.sv
// Host command/response stream between the AXI register file and the sequencer.
interface mips_debug_sequencer_if;
  import mips_dbg_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [PMEM_AW-1:0] cmd_addr;
  logic [31:0]        cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic               rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_last
  );

endinterface

// File: rtl/mips_debug_sequencer_clk_pulser.sv
// Emits a counted burst of core clock cycles, each HALF_PERIOD sysclks high then low.
module dbg_clk_pulser #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cycles,
  output logic        core_clk,
  output logic        busy,
  output logic        phase_end,
  output logic        last_cycle,
  output logic        done
);

  logic [7:0]  phase_cnt;
  logic [15:0] cyc_rem;

  assign phase_end  = busy && (phase_cnt == 8'(HALF_PERIOD - 1));
  assign last_cycle = (cyc_rem == 16'd1);
  assign done       = phase_end && !core_clk && last_cycle;

  // Remaining-cycle count runs down to 1 so a full 16-bit N never wraps early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      core_clk  <= 1'b0;
      phase_cnt <= 8'd0;
      cyc_rem   <= 16'd0;
    end else if (start && (cycles != 16'd0)) begin
      busy      <= 1'b1;
      core_clk  <= 1'b1;
      phase_cnt <= 8'd0;
      cyc_rem   <= cycles;
    end else if (phase_end) begin
      phase_cnt <= 8'd0;
      if (core_clk) begin
        core_clk <= 1'b0;
      end else if (last_cycle) begin
        busy    <= 1'b0;
        cyc_rem <= 16'd0;
      end else begin
        core_clk <= 1'b1;
        cyc_rem  <= cyc_rem - 16'd1;
      end
    end else if (busy) begin
      phase_cnt <= phase_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mips_debug_sequencer.sv
// Host-side LOAD/STEP/RST/DUMP command sequencer for the single-cycle MIPS harness.
module mips_debug_sequencer
  import mips_dbg_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int RST_CYCLES  = 8,
  parameter int RD_LAT      = 2
) (
  input  logic                clk_100MHz,
  input  logic                rst_n,
  mips_debug_sequencer_if.slave host,
  output logic                busy,
  output logic                core_clk,
  output logic                core_clk_sel,
  output logic                core_rst,
  output logic                pmem_we,
  output logic [PMEM_AW-1:0]  pmem_addr,
  output logic [31:0]         pmem_wd,
  input  logic [31:0]         pmem_rd,
  output logic [RF_AW-1:0]    rf_addr,
  input  logic [31:0]         rf_data,
  input  logic [31:0]         pc_current
);

  dbg_state_e         state, state_next;
  logic [1:0]         op_q;
  logic [PMEM_AW-1:0] addr_q;
  logic [31:0]        data_q;
  logic [RF_AW-1:0]   reg_idx;
  logic [15:0]        wait_cnt;
  logic [31:0]        rsp_q;
  logic               ready_en;
  logic               accept, pulse_start, dump_more, rd_done, hold_done;
  logic [15:0]        pulse_cycles;
  logic               pulse_busy, phase_end, last_cycle, pulse_done;

  assign accept       = host.cmd_valid && host.cmd_ready;
  assign pulse_start  = accept && ((host.cmd_op == OP_STEP) || (host.cmd_op == OP_RST));
  assign pulse_cycles = (host.cmd_op == OP_RST) ? 16'd1 : host.cmd_data[15:0];
  assign dump_more    = (op_q == OP_DUMP) && (reg_idx != RF_AW'(RF_DEPTH - 1));
  assign rd_done      = (wait_cnt == 16'(RD_LAT - 1));
  assign hold_done    = (wait_cnt >= 16'(RST_CYCLES - 1));

  dbg_clk_pulser #(.HALF_PERIOD(HALF_PERIOD)) u_pulser (
    .clk        (clk_100MHz),
    .rst_n      (rst_n),
    .start      (pulse_start),
    .cycles     (pulse_cycles),
    .core_clk   (core_clk),
    .busy       (pulse_busy),
    .phase_end  (phase_end),
    .last_cycle (last_cycle),
    .done       (pulse_done)
  );

  // The reset hold only ends once both the minimum hold and the clock pulse are over.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (host.cmd_op)
            OP_LOAD: state_next = LD_WR;
            OP_STEP: state_next = (host.cmd_data[15:0] == 16'd0) ? RSP : CLK_HI;
            OP_RST:  state_next = RST_HOLD;
            default: state_next = DMP_SET;
          endcase
        end
      end
      LD_WR:    state_next = RD_WAIT;
      RD_WAIT:  if (rd_done) state_next = RSP;
      CLK_HI:   if (phase_end) state_next = CLK_LO;
      CLK_LO:   if (phase_end) state_next = last_cycle ? RSP : CLK_HI;
      RST_HOLD: if (hold_done && (pulse_done || !pulse_busy)) state_next = RSP;
      DMP_SET:  state_next = RD_WAIT;
      RSP:      if (host.rsp_ready) state_next = dump_more ? DMP_SET : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
      op_q     <= OP_LOAD;
      addr_q   <= '0;
      data_q   <= 32'd0;
      reg_idx  <= '0;
      wait_cnt <= 16'd0;
      rsp_q    <= 32'd0;
      core_rst <= 1'b1;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (accept) begin
        op_q   <= host.cmd_op;
        addr_q <= host.cmd_addr;
        data_q <= host.cmd_data;
      end
      if (accept && (host.cmd_op == OP_DUMP)) begin
        reg_idx <= '0;
      end else if ((state == RSP) && host.rsp_ready && dump_more) begin
        reg_idx <= reg_idx + 1'b1;
      end
      if (state_next != state) begin
        wait_cnt <= 16'd0;
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      // Response payload is frozen on entry to RSP so it stays stable under backpressure.
      if ((state_next == RSP) && (state != RSP)) begin
        if (state == RD_WAIT) begin
          rsp_q <= (op_q == OP_LOAD) ? pmem_rd : rf_data;
        end else begin
          rsp_q <= pc_current;
        end
      end
      if (accept && (host.cmd_op == OP_RST)) begin
        core_rst <= 1'b1;
      end else if ((state == RST_HOLD) && (state_next == RSP)) begin
        core_rst <= 1'b0;
      end
    end
  end

  assign host.cmd_ready = ready_en && (state == IDLE);
  assign host.rsp_valid = (state == RSP);
  assign host.rsp_data  = rsp_q;
  assign host.rsp_last  = (state == RSP) && !dump_more;
  assign busy           = (state != IDLE);
  assign core_clk_sel   = 1'b0;
  assign pmem_we        = (state == LD_WR);
  assign pmem_addr      = addr_q;
  assign pmem_wd        = data_q;
  assign rf_addr        = reg_idx;

endmodule

// File: tb/tb_mips_debug_sequencer.sv
// Directed bench for mips_debug_sequencer with pmem, register-file and core PC models.
module tb_mips_debug_sequencer;
  import mips_dbg_pkg::*;

  localparam int HALF_PERIOD = 4;
  localparam int RST_CYCLES  = 8;
  localparam int RD_LAT      = 2;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_pulses;
    int          exp_we;
    logic        exp_core_rst;
  } vec_t;

  logic        clk_100MHz;
  logic        rst_n;
  logic        busy, core_clk, core_clk_sel, core_rst, pmem_we;
  logic [5:0]  pmem_addr;
  logic [31:0] pmem_wd, pmem_rd, rf_data, pc_current;
  logic [4:0]  rf_addr;

  mips_debug_sequencer_if bus ();

  mips_debug_sequencer #(
    .HALF_PERIOD (HALF_PERIOD),
    .RST_CYCLES  (RST_CYCLES),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .rst_n        (rst_n),
    .host         (bus),
    .busy         (busy),
    .core_clk     (core_clk),
    .core_clk_sel (core_clk_sel),
    .core_rst     (core_rst),
    .pmem_we      (pmem_we),
    .pmem_addr    (pmem_addr),
    .pmem_wd      (pmem_wd),
    .pmem_rd      (pmem_rd),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .pc_current   (pc_current)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  function automatic logic [31:0] rf_val(input int r);
    return 32'hCAFE_0000 | (32'(r) * 32'h0000_0101);
  endfunction

  // Write-first program memory and register file, both with a two-register read path.
  logic [31:0] pmem [0:63];
  logic [31:0] pmem_p1, pmem_p2, rf_p1, rf_p2;
  initial for (int i = 0; i < 64; i++) pmem[i] = 32'hBAD0_0000 + 32'(i);
  always @(posedge clk_100MHz) begin
    if (pmem_we) begin
      pmem[pmem_addr] <= pmem_wd;
      pmem_p1         <= pmem_wd;
    end else begin
      pmem_p1 <= pmem[pmem_addr];
    end
    pmem_p2 <= pmem_p1;
    rf_p1   <= rf_val(int'(rf_addr));
    rf_p2   <= rf_p1;
  end
  assign pmem_rd = pmem_p2;
  assign rf_data = rf_p2;

  // Core PC: synchronous reset, otherwise advances one word per core clock.
  logic [31:0] pc;
  initial pc = 32'h0000_0400;
  always @(posedge core_clk) pc <= core_rst ? 32'd0 : pc + 32'd4;
  assign pc_current = pc;

  int   rises = 0, we_count = 0, bad_phase = 0, run_len = 0;
  bit   clk_prev = 1'b0, lo_armed = 1'b0;
  logic [5:0]  we_addr = '0;
  logic [31:0] we_data = '0;
  always @(negedge clk_100MHz) begin
    if (!rst_n) begin
      clk_prev = core_clk;
      run_len  = 0;
      lo_armed = 1'b0;
    end else begin
      if (core_clk && !clk_prev) begin
        rises++;
        if (lo_armed && (run_len != HALF_PERIOD)) bad_phase++;
        run_len = 1;
      end else if (!core_clk && clk_prev) begin
        if (run_len != HALF_PERIOD) bad_phase++;
        run_len  = 1;
        lo_armed = 1'b1;
      end else begin
        run_len++;
      end
      if (bus.rsp_valid || !busy) lo_armed = 1'b0;
      clk_prev = core_clk;
      if (pmem_we) begin
        we_count++;
        we_addr = pmem_addr;
        we_data = pmem_wd;
      end
    end
  end

  int passed = 0, total = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v, output int lat, output int pulses, output int wes);
    int r0, w0, seen;
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk_100MHz);
    checkOutput("cmd_ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_addr  = v.addr;
    bus.cmd_data  = v.data;
    r0 = rises;
    w0 = we_count;
    @(negedge clk_100MHz);
    bus.cmd_valid = 1'b0;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk_100MHz);
      lat++;
    end
    checkOutput("rsp_timeout", 32'(seen), 32'd1);
    pulses = rises - r0;
    wes    = we_count - w0;
  endtask

  task automatic runVector(input int idx, input vec_t v);
    int lat, pulses, wes;
    applyStimulus(v, lat, pulses, wes);
    checkOutput($sformatf("v%0d_rsp_data", idx), bus.rsp_data, v.exp_data);
    checkOutput($sformatf("v%0d_rsp_last", idx), 32'(bus.rsp_last), 32'd1);
    checkOutput($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    checkOutput($sformatf("v%0d_core_clk_pulses", idx), 32'(pulses), 32'(v.exp_pulses));
    checkOutput($sformatf("v%0d_pmem_we_cycles", idx), 32'(wes), 32'(v.exp_we));
    checkOutput($sformatf("v%0d_core_rst", idx), 32'(core_rst), 32'(v.exp_core_rst));
    if (v.op == OP_LOAD) begin
      checkOutput($sformatf("v%0d_pmem_wr_addr", idx), 32'(we_addr), 32'(v.addr));
      checkOutput($sformatf("v%0d_pmem_wr_data", idx), we_data, v.data);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk_100MHz);
    bus.rsp_ready = 1'b0;
    checkOutput($sformatf("v%0d_idle_after_rsp", idx), 32'({busy, bus.cmd_ready}), 32'd1);
  endtask

  vec_t vecs [11];
  int   r0, seen, stray;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{OP_LOAD, 6'd5,  32'h2008_000A, 32'h2008_000A, 3,  0, 1, 1'b1};
    vecs[1]  = '{OP_LOAD, 6'd63, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3,  0, 1, 1'b1};
    vecs[2]  = '{OP_RST,  6'd0,  32'h0000_0000, 32'h0000_0000, 8,  1, 0, 1'b0};
    vecs[3]  = '{OP_STEP, 6'd0,  32'h0000_0003, 32'h0000_000C, 24, 3, 0, 1'b0};
    vecs[4]  = '{OP_STEP, 6'd0,  32'h0000_0000, 32'h0000_000C, 0,  0, 0, 1'b0};
    vecs[5]  = '{OP_STEP, 6'd0,  32'h0000_0001, 32'h0000_0010, 8,  1, 0, 1'b0};
    vecs[6]  = '{OP_LOAD, 6'd0,  32'h0000_0001, 32'h0000_0001, 3,  0, 1, 1'b0};
    vecs[7]  = '{OP_RST,  6'd0,  32'h0000_0000, 32'h0000_0000, 8,  1, 0, 1'b0};
    vecs[8]  = '{OP_STEP, 6'd0,  32'hFFFF_0002, 32'h0000_0008, 16, 2, 0, 1'b0};
    vecs[9]  = '{OP_RST,  6'd0,  32'h0000_0000, 32'h0000_0000, 8,  1, 0, 1'b0};
    vecs[10] = '{OP_STEP, 6'd0,  32'h0000_0001, 32'h0000_0004, 8,  1, 0, 1'b0};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    checkOutput("reset_core_rst", 32'(core_rst), 32'd1);
    checkOutput("reset_core_clk", 32'(core_clk), 32'd0);
    checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("reset_outputs", 32'({bus.rsp_valid, busy, pmem_we, core_clk_sel}), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_cmd_ready_same_cycle", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk_100MHz);
    checkOutput("release_cmd_ready_next_cycle", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++) runVector(i, vecs[i]);

    // DUMP with rsp_ready toggling: every response is stalled one cycle, then taken.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_DUMP;
    r0 = rises;
    @(negedge clk_100MHz);
    bus.cmd_valid = 1'b0;
    for (int r = 0; r < 32; r++) begin
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (bus.rsp_valid) begin
          seen = 1;
          break;
        end
        @(negedge clk_100MHz);
      end
      if (seen == 0) begin
        checkOutput($sformatf("dump%0d_timeout", r), 32'd0, 32'd1);
        break;
      end
      checkOutput($sformatf("dump%0d_data", r), bus.rsp_data, rf_val(r));
      checkOutput($sformatf("dump%0d_last", r), 32'(bus.rsp_last), (r == 31) ? 32'd1 : 32'd0);
      @(negedge clk_100MHz);
      checkOutput($sformatf("dump%0d_stall_valid", r), 32'(bus.rsp_valid), 32'd1);
      checkOutput($sformatf("dump%0d_stall_data", r), bus.rsp_data, rf_val(r));
      bus.rsp_ready = 1'b1;
      @(negedge clk_100MHz);
      bus.rsp_ready = 1'b0;
    end
    checkOutput("dump_idle_after", 32'({busy, bus.cmd_ready}), 32'd1);
    checkOutput("dump_no_core_clk", 32'(rises - r0), 32'd0);

    // Asynchronous reset in the middle of a long STEP.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_STEP;
    bus.cmd_data  = 32'd100;
    @(negedge clk_100MHz);
    bus.cmd_valid = 1'b0;
    @(negedge clk_100MHz);
    checkOutput("midstep_core_clk_high", 32'(core_clk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midstep_async_core_clk", 32'(core_clk), 32'd0);
    checkOutput("midstep_async_core_rst", 32'(core_rst), 32'd1);
    checkOutput("midstep_async_idle", 32'({bus.rsp_valid, busy, bus.cmd_ready}), 32'd0);
    repeat (2) @(negedge clk_100MHz);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_100MHz);
      if (bus.rsp_valid) stray++;
    end
    checkOutput("midstep_no_response", 32'(stray), 32'd0);
    runVector(9, vecs[9]);
    runVector(10, vecs[10]);

    checkOutput("core_clk_phase_lengths", 32'(bad_phase), 32'd0);
    checkOutput("core_clk_sel_const", 32'(core_clk_sel), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
